// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment capture decoder.
// Segment bit order is a (bit0) through g (bit6); 1 means the segment is lit.
package seg7_pkg;

    typedef enum logic [1:0] {
        WAIT_CHANGE = 2'd0,
        SETTLE      = 2'd1,
        REPORT      = 2'd2
    } seg7_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index is the hex value shown by the pattern.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_capture_decoder_lookup.sv
// Combinational reverse lookup from a segment pattern to its hex digit.
// hit is low (and digit 0) for blank and for any pattern not in SEG_TABLE.
module seg7_pat_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] digit,
    output logic       hit
);

    always_comb begin
        digit = 4'd0;
        hit   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG_TABLE[i]) begin
                digit = 4'(i);
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Debounces a seven-segment bus and reports each newly settled digit as a
// valid/ready event. Define SEG7_DECODE_ERR_EN to report unknown patterns via err.
//
// state       | meaning
// WAIT_CHANGE | idle until the sampled pattern differs from the last settled one
// SETTLE      | counting consecutive identical samples of the candidate pattern
// REPORT      | candidate settled; decode it and raise an event if reportable
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic       overrun
`ifdef SEG7_DECODE_ERR_EN
    ,
    output logic       err
`endif
);

    localparam logic [7:0] STABLE_U8 = 8'(STABLE_CYCLES);

    seg7_state_e state_q, state_d;
    logic [6:0]  seg_q, seg_d;
    logic [6:0]  cand_q, cand_d;
    logic [6:0]  last_pat_q, last_pat_d;
    logic [7:0]  stab_cnt_q, stab_cnt_d;
    logic [3:0]  digit_q, digit_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic        ev_fire;
    logic [3:0]  lk_digit;
    logic        lk_hit;
`ifdef SEG7_DECODE_ERR_EN
    logic        err_q, err_d;
    logic        ev_err;
`endif

    seg7_pat_lookup u_lookup (
        .pat   (last_pat_q),
        .digit (lk_digit),
        .hit   (lk_hit)
    );

    assign seg_d = seg_in;

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        last_pat_d = last_pat_q;
        stab_cnt_d = stab_cnt_q;
        ev_fire    = 1'b0;
`ifdef SEG7_DECODE_ERR_EN
        ev_err     = 1'b0;
`endif
        case (state_q)
            WAIT_CHANGE: begin
                if (seg_q != last_pat_q) begin
                    cand_d     = seg_q;
                    stab_cnt_d = 8'd1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                // Settled pattern equal to the last one (bounce back) is silent.
                if (stab_cnt_q >= STABLE_U8) begin
                    last_pat_d = cand_q;
                    state_d    = (cand_q == last_pat_q) ? WAIT_CHANGE : REPORT;
                end else if (seg_q == cand_q) begin
                    stab_cnt_d = stab_cnt_q + 8'd1;
                end else begin
                    cand_d     = seg_q;
                    stab_cnt_d = 8'd1;
                end
            end
            REPORT: begin
                state_d = WAIT_CHANGE;
                if (lk_hit) begin
                    ev_fire = 1'b1;
                end
`ifdef SEG7_DECODE_ERR_EN
                else if (last_pat_q != SEG_BLANK) begin
                    ev_fire = 1'b1;
                    ev_err  = 1'b1;
                end
`endif
            end
            default: state_d = WAIT_CHANGE;
        endcase
    end

    // Single-entry event holding register; a new event is only taken when the
    // slot is free or being drained on the same edge.
    always_comb begin
        digit_d   = digit_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef SEG7_DECODE_ERR_EN
        err_d     = err_q;
`endif
        if (valid_q && digit_ready) begin
            valid_d = 1'b0;
        end
        if (ev_fire) begin
            if (!valid_q || digit_ready) begin
                valid_d = 1'b1;
                digit_d = lk_digit;
`ifdef SEG7_DECODE_ERR_EN
                err_d   = ev_err;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_CHANGE;
            seg_q      <= SEG_BLANK;
            cand_q     <= SEG_BLANK;
            last_pat_q <= SEG_BLANK;
            stab_cnt_q <= 8'd0;
            digit_q    <= 4'd0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef SEG7_DECODE_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            cand_q     <= cand_d;
            last_pat_q <= last_pat_d;
            stab_cnt_q <= stab_cnt_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
`ifdef SEG7_DECODE_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign overrun     = overrun_q;
`ifdef SEG7_DECODE_ERR_EN
    assign err         = err_q;
`endif

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Randomized and directed bench for seg7_capture_decoder against a timestamped
// settle/report model; checks every cycle plus scenario-level event counts.
module tb_seg7_capture_decoder;

    localparam int S = 4;
`ifdef SEG7_DECODE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = 7'h00;
    logic       digit_ready = 1'b0;
    logic [3:0] digit;
    logic       digit_valid;
    logic       overrun;
`ifdef SEG7_DECODE_ERR_EN
    logic       err;
`endif

    seg7_capture_decoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .overrun     (overrun)
`ifdef SEG7_DECODE_ERR_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    logic [6:0] hex_pat [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the sampled pattern stream, the last settled pattern, the
    // current run (value, length; 0 = not tracking) and a one-cycle report slot.
    logic [6:0] m_smp = 7'h00, m_last = 7'h00, m_run = 7'h00;
    int         m_len = 0;
    bit         m_rpt = 1'b0;
    bit         e_valid = 1'b0, e_ovr = 1'b0, e_err = 1'b0;
    logic [3:0] e_digit = 4'h0;

    function automatic int hex_of(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (hex_pat[i] == p) return i;
        return -1;
    endfunction

    task automatic model_step(input bit r, input logic [6:0] s, input bit rdy);
        bit ev = 1'b0, ev_e = 1'b0, was_valid;
        int idx;
        logic [3:0] ev_d = 4'h0;
        if (r) begin
            m_smp = 7'h00; m_last = 7'h00; m_run = 7'h00; m_len = 0; m_rpt = 1'b0;
            e_valid = 1'b0; e_ovr = 1'b0; e_err = 1'b0; e_digit = 4'h0;
            return;
        end
        if (m_rpt) begin
            m_rpt = 1'b0;
            idx = hex_of(m_last);
            if (idx >= 0) begin
                ev = 1'b1; ev_d = 4'(idx);
            end else if (ERR_EN && m_last != 7'h00) begin
                ev = 1'b1; ev_e = 1'b1;
            end
        end else if (m_len == 0) begin
            if (m_smp != m_last) begin m_run = m_smp; m_len = 1; end
        end else if (m_len >= S) begin
            if (m_run != m_last) m_rpt = 1'b1;
            m_last = m_run;
            m_len = 0;
        end else if (m_smp == m_run) begin
            m_len++;
        end else begin
            m_run = m_smp; m_len = 1;
        end
        was_valid = e_valid;
        if (e_valid && rdy) e_valid = 1'b0;
        if (ev) begin
            if (!was_valid || rdy) begin
                e_valid = 1'b1; e_digit = ev_d; e_err = ev_e;
            end else begin
                e_ovr = 1'b1;
            end
        end
        m_smp = s;
    endtask

    int         n_acc = 0, cyc_i = 0, first_v = -1;
    logic [3:0] acc_digit = 4'h0;
    logic       acc_err = 1'b0;

    task automatic cyc(input logic [6:0] s, input bit rdy, input bit r);
        seg_in = s; digit_ready = rdy; rst = r;
        if (digit_valid === 1'b1 && rdy && !r) begin
            n_acc++;
            acc_digit = digit;
`ifdef SEG7_DECODE_ERR_EN
            acc_err = err;
`endif
        end
        @(posedge clk);
        model_step(r, s, rdy);
        @(negedge clk);
        cyc_i++;
        if (digit_valid === 1'b1 && first_v < 0) first_v = cyc_i;
        check("valid", digit_valid, e_valid);
        if (e_valid) check("digit", digit, e_digit);
        check("overrun", overrun, e_ovr);
`ifdef SEG7_DECODE_ERR_EN
        if (e_valid) check("err", err, e_err);
`endif
    endtask

    task automatic hold(input logic [6:0] s, input bit rdy, input int n);
        for (int k = 0; k < n; k++) cyc(s, rdy, 1'b0);
    endtask

    task automatic mark();
        n_acc = 0; cyc_i = 0; first_v = -1; acc_err = 1'b0;
    endtask

    initial begin
        int len;
        logic [6:0] p;
        @(negedge clk);
        cyc(7'h00, 1'b1, 1'b1);
        cyc(7'h00, 1'b1, 1'b1);
        check("rst_valid", digit_valid, 0);
        check("rst_digit", digit, 0);
        check("rst_overrun", overrun, 0);
        hold(7'h00, 1'b1, 4);

        // 06 held with ready: single event, first visible 7 edges after apply
        mark();
        hold(7'h06, 1'b1, 10);
        check("t1_first", first_v, 7);
        check("t1_events", n_acc, 1);
        check("t1_digit", acc_digit, 1);
        hold(7'h00, 1'b1, 8);

        // bouncing 5B/4F never settles, then 4F settles once
        mark();
        for (int k = 0; k < 5; k++) begin
            hold(7'h5B, 1'b1, 3);
            hold(7'h4F, 1'b1, 3);
        end
        check("t2_bounce_events", n_acc, 0);
        hold(7'h4F, 1'b1, 10);
        check("t2_events", n_acc, 1);
        check("t2_digit", acc_digit, 3);
        hold(7'h00, 1'b1, 8);

        // repeated digit separated by blank is reported twice
        mark();
        hold(7'h7F, 1'b1, 8);
        hold(7'h00, 1'b1, 8);
        hold(7'h7F, 1'b1, 8);
        hold(7'h7F, 1'b1, 2);
        check("t3_events", n_acc, 2);
        check("t3_digit", acc_digit, 8);

        // second event while stalled is dropped and flags overrun
        mark();
        hold(7'h66, 1'b0, 8);
        hold(7'h6D, 1'b0, 8);
        check("t4_digit_held", digit, 4);
        check("t4_valid_held", digit_valid, 1);
        check("t4_overrun", overrun, 1);
        hold(7'h6D, 1'b1, 1);
        check("t4_drained", digit_valid, 0);
        hold(7'h6D, 1'b1, 4);
        check("t4_accepts", n_acc, 1);
        check("t4_overrun_sticky", overrun, 1);

        // reset mid-settle, then reset with an undelivered digit pending
        hold(7'h7F, 1'b0, 3);
        cyc(7'h7F, 1'b0, 1'b1);
        check("t5a_valid", digit_valid, 0);
        check("t5a_overrun", overrun, 0);
        hold(7'h7F, 1'b0, 10);
        check("t5_pending", digit_valid, 1);
        cyc(7'h7F, 1'b0, 1'b1);
        check("t5b_valid", digit_valid, 0);
        check("t5b_digit", digit, 0);
        mark();
        hold(7'h7F, 1'b0, 8);
        check("t5_first", first_v, 7);
        check("t5_digit", digit, 8);
        hold(7'h7F, 1'b1, 3);
        hold(7'h00, 1'b1, 8);

        // unknown pattern 49
        mark();
        hold(7'h49, 1'b1, 12);
        check("t6_events", n_acc, ERR_EN ? 1 : 0);
        if (ERR_EN) begin
            check("t6_digit", acc_digit, 0);
            check("t6_err", acc_err, 1);
        end
        hold(7'h00, 1'b1, 8);

        // random segments: mostly table patterns, some blank/unknown, random hold
        for (int seg = 0; seg < 250; seg++) begin
            case ($urandom_range(0, 9))
                0:       p = 7'h00;
                1:       p = 7'($urandom);
                default: p = hex_pat[$urandom_range(0, 15)];
            endcase
            len = $urandom_range(1, 11);
            for (int k = 0; k < len; k++)
                cyc(p, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seg7_capture_decoder.md
SEG7_CAPTURE_DECODER -- requirements
Module: seg7_capture_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required before a pattern is accepted.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port seg_in, input, 7: segment levels, bit0=a through bit6=g, 1=lit.
REQ-005 SHALL have port digit, output, 4: decoded hex value.
REQ-006 SHALL have port digit_valid, output, 1: digit holds an unconsumed event.
REQ-007 SHALL have port digit_ready, input, 1: consumer accepts the event when digit_valid and digit_ready are both 1 at a rising edge.
REQ-008 SHALL have port overrun, output, 1: sticky flag, an accepted pattern was dropped.
REQ-009 SHALL have port err, output, 1: the event is an unknown pattern (present only with SEG7_DECODE_ERR_EN).

Function
REQ-010 SHALL register seg_in once (seg_q) before any comparison.
REQ-011 SHALL use FSM states WAIT_CHANGE, SETTLE and REPORT.
REQ-012 In WAIT_CHANGE, a seg_q value different from last_pat SHALL load stab_cnt=1 and move to SETTLE.
REQ-013 In SETTLE, seg_q equal to the previous sample SHALL increment stab_cnt; seg_q different SHALL restart stab_cnt=1 with the new value.
REQ-014 In SETTLE, when stab_cnt reaches STABLE_CYCLES, the FSM SHALL update last_pat and move to REPORT; a pattern equal to last_pat SHALL return to WAIT_CHANGE without an event.
REQ-015 In REPORT, a pattern in the 16-entry hex table SHALL raise an event; the FSM SHALL then return to WAIT_CHANGE after 1 cycle.
REQ-016 The hex table SHALL be, for 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-017 Pattern 00 (blank) SHALL set last_pat=00 and emit no event, so a repeated digit separated by a blank is reported again.
REQ-018 Latency: with seg_in constant from edge N, digit_valid SHALL be 1 after edge N+STABLE_CYCLES+2.
REQ-019 digit, digit_valid and err SHALL be registered and held stable while digit_valid=1 and digit_ready=0.
REQ-020 On accept, with no new event in the same cycle, digit_valid SHALL deassert on that edge.
REQ-021 A new event in the same cycle as an accept SHALL load the new event, with digit_valid remaining 1.
REQ-022 A new event while digit_valid=1 and digit_ready=0 SHALL be dropped and SHALL set overrun.
REQ-023 overrun SHALL clear only on rst.
REQ-024 A non-table, non-blank pattern SHALL follow SEG7_DECODE_ERR_EN (REQ-029/030).

Reset
REQ-025 rst=1 SHALL force state=WAIT_CHANGE, seg_q=00, last_pat=00, stab_cnt=0, digit=0, digit_valid=0, overrun=0, err=0 at the next edge.
REQ-026 rst SHALL take priority over every other event, including mid-SETTLE and a pending unaccepted digit, which is discarded.
REQ-027 After rst deasserts, a stable non-blank pattern SHALL be reported per REQ-018.

Configuration
REQ-028 Macro SEG7_DECODE_ERR_EN SHALL select unknown-pattern handling.
REQ-029 With SEG7_DECODE_ERR_EN defined: the err port SHALL exist, and an unknown pattern SHALL raise an event with digit=0 and err=1.
REQ-030 With SEG7_DECODE_ERR_EN undefined: the err port SHALL be absent, and an unknown pattern SHALL update last_pat and raise no event.

Structure
REQ-031 A shared package seg7_pkg SHALL hold the state enum, the SEG_BLANK constant and the 16-entry pattern table constant.
REQ-032 Sub-module seg7_pat_lookup SHALL be combinational: 7-bit pattern in; 4-bit digit and 1-bit hit out.
REQ-033 Sub-module seg7_pat_lookup SHALL be the only sub-module.

Verification
REQ-034 seg_in=06 held for 10 cycles, STABLE_CYCLES=4, digit_ready=1 -> one digit_valid pulse with digit=1, first at edge N+6.
REQ-035 seg_in toggling 5B/4F every 3 cycles for 30 cycles -> no event; then 4F held -> one event with digit=3.
REQ-036 Sequence 7F, 00, 7F, each held for 8 cycles, digit_ready=1 -> two events with digit=8.
REQ-037 Events 66 then 6D with digit_ready=0 -> digit=4 held; overrun=1; after digit_ready=1, a single accept, then digit_valid=0.
REQ-038 seg_in=7F held and rst pulsed mid-SETTLE, then while valid pending -> all outputs 0 after the rst edge; digit=8 reported again 6 cycles after release.
REQ-039 seg_in=49 held, digit_ready=1 -> with SEG7_DECODE_ERR_EN, one event with err=1 and digit=0; without it, no event.
